// File: rtl/pc_pkg.sv
// Shared encodings and types for the program-counter register and next-PC selector.
package pc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
  localparam logic [1:0] PC_SRC_BR   = 2'b01;
  localparam logic [1:0] PC_SRC_JALR = 2'b10;
  localparam logic [1:0] PC_SRC_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_target_check.sv
// Combinational next-PC candidate mux with illegal-select and IALIGN=32 fault detection.
module pc_target_check
  import pc_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [1:0]      pc_src_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic [XLEN-1:0] target_o,
  output logic            fault_o
);

  logic illegal;

  always_comb begin
    target_o = pc_plus4_i;
    illegal  = 1'b0;
    unique case (pc_src_i)
      PC_SRC_SEQ:  target_o = pc_plus4_i;
      PC_SRC_BR:   target_o = branch_target_i;
      // JALR clears bit 0 of the computed address.
      PC_SRC_JALR: target_o = {jalr_target_i[XLEN-1:1], 1'b0};
      default:     illegal  = 1'b1;
    endcase
    fault_o = illegal | (target_o[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_next_reg.sv
// Architectural PC register with boot delay, stall, sticky trap on bad targets and retire count.
module pc_next_reg
  import pc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     BOOT_CYCLES  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic [1:0]      pc_src_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pc_valid_o,
  output logic            trap_o,
  output logic [XLEN-1:0] trap_pc_o,
  output logic [XLEN-1:0] instr_count_o
);

  localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

  pc_state_t       state_q, state_d;
  logic [3:0]      boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_cnt_q, instr_cnt_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;

  logic [XLEN-1:0] target;
  logic            fault;

  assign pc_plus4_o = pc_q + 32'd4;

  pc_target_check u_target_check (
    .pc_plus4_i      (pc_plus4_o),
    .pc_src_i        (pc_src_i),
    .branch_target_i (branch_target_i),
    .jalr_target_i   (jalr_target_i),
    .target_o        (target),
    .fault_o         (fault)
  );

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pc_d        = pc_q;
    instr_cnt_d = instr_cnt_q;
    trap_d      = trap_q;
    trap_pc_d   = trap_pc_q;
    unique case (state_q)
      StBoot: begin
        if (boot_cnt_q == BootLast) begin
          state_d = StRun;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      StRun: begin
        // Stall masks both the update and the fault check.
        if (!stall_i) begin
          if (fault) begin
            state_d   = StHalt;
            trap_d    = 1'b1;
            trap_pc_d = pc_q;
          end else begin
            pc_d        = target;
            instr_cnt_d = instr_cnt_q + 32'd1;
          end
        end
      end
      StHalt: ;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StBoot;
      boot_cnt_q  <= 4'd0;
      pc_q        <= RESET_VECTOR;
      instr_cnt_q <= '0;
      trap_q      <= 1'b0;
      trap_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pc_q        <= pc_d;
      instr_cnt_q <= instr_cnt_d;
      trap_q      <= trap_d;
      trap_pc_q   <= trap_pc_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_valid_o    = (state_q == StRun) && !stall_i;
  assign trap_o        = trap_q;
  assign trap_pc_o     = trap_pc_q;
  assign instr_count_o = instr_cnt_q;

endmodule
